// File: rtl/cci_rd_req_arb_pkg.sv
// rtl/cci_rd_req_arb_pkg.sv - shared types and constants for the c0 read-request arbiter
// Contents:
//   REQ_ID_LSB        bit position of the requester id inside the 16-bit c0 mdata
//   CL_ADDR_W         cache-line address width
//   t_req_id          3-bit requester id carried in c0 mdata[15:13]
//   t_user_mdata      13-bit user tag owned by the requester
//   t_outstanding_cnt 8-bit per-requester in-flight counter
//   t_c0_mdata        packed view of the 16-bit c0 mdata field
package cci_rd_req_arb_pkg;

    localparam int REQ_ID_LSB = 13;
    localparam int CL_ADDR_W  = 42;

    typedef logic [2:0]           t_req_id;
    typedef logic [12:0]          t_user_mdata;
    typedef logic [7:0]           t_outstanding_cnt;
    typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;

    typedef struct packed {
        t_req_id     reqId;
        t_user_mdata user;
    } t_c0_mdata;

endpackage

// File: rtl/cci_rd_req_arb_rr.sv
// rtl/cci_rd_req_arb_rr.sv - round-robin one-hot selector
// Ports:
//   eligible  in   N_REQ  requesters allowed to win this cycle
//   rrPtr     in   IDX_W  index where the search starts
//   grant     out  N_REQ  one-hot winner, all zero when nothing is eligible
module cci_rd_req_arb_rr
    import cci_rd_req_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] rrPtr,
    output logic [N_REQ-1:0] grant
);

    // One extra bit so rrPtr + k can exceed N_REQ-1 before folding back.
    logic [IDX_W:0] slot;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            slot = {1'b0, rrPtr} + (IDX_W+1)'(k);
            if (slot >= (IDX_W+1)'(N_REQ)) begin
                slot = slot - (IDX_W+1)'(N_REQ);
            end
            if (!found && eligible[slot[IDX_W-1:0]]) begin
                grant[slot[IDX_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cci_rd_req_arb.sv
// rtl/cci_rd_req_arb.sv - N-way round-robin arbiter for the CCI-P c0 read-request channel
// Optional feature macro: CCI_RD_REQ_ARB_STATS_EN (adds stat_grants grant counters)
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req_valid/addr/mdata        per-requester read request (flattened N_REQ x width)
//   req_grant                   one-hot combinational accept
//   c0TxAlmFull                 FIU back-pressure, blocks new grants
//   c0_tx_valid/addr/mdata      registered request to the FIU, mdata = {id, user tag}
//   c0_rx_rdValid/mdata         read response from the FIU
//   rsp_valid/rsp_mdata         registered one-hot response routing and user tag
//   stat_grants                 per-requester 32-bit grant counters (macro only)
module cci_rd_req_arb
    import cci_rd_req_arb_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*CL_ADDR_W-1:0] req_addr,
    input  logic [N_REQ*13-1:0]        req_mdata,
    output logic [N_REQ-1:0]           req_grant,
    input  logic                       c0TxAlmFull,
`ifdef CCI_RD_REQ_ARB_STATS_EN
    output logic [N_REQ*32-1:0]        stat_grants,
`endif
    output logic                       c0_tx_valid,
    output logic [CL_ADDR_W-1:0]       c0_tx_addr,
    output logic [15:0]                c0_tx_mdata,
    input  logic                       c0_rx_rdValid,
    input  logic [15:0]                c0_rx_mdata,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [12:0]                rsp_mdata
);

    localparam int IDX_W = $clog2(N_REQ);

    t_outstanding_cnt outstanding [N_REQ];
    logic [IDX_W-1:0] rrPtr;
    logic [IDX_W-1:0] gntIdx;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] rspHit;
    t_ccip_clAddr     gntAddr;
    t_user_mdata      gntMdata;
    t_req_id          rspId;

    assign rspId = c0_rx_mdata[REQ_ID_LSB +: 3];

    // Reset is folded into eligibility so req_grant is quiet during reset.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && !c0TxAlmFull && !reset &&
                          (outstanding[i] < t_outstanding_cnt'(MAX_OUTSTANDING));
        end
    end

    cci_rd_req_arb_rr #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .eligible (eligible),
        .rrPtr    (rrPtr),
        .grant    (grant)
    );

    assign req_grant = grant;

    // Encode the one-hot winner and pick its payload.
    always_comb begin
        gntIdx   = '0;
        gntAddr  = '0;
        gntMdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gntIdx   = IDX_W'(i);
                gntAddr  = req_addr[i*CL_ADDR_W +: CL_ADDR_W];
                gntMdata = req_mdata[i*13 +: 13];
            end
        end
    end

    // Ids at or above N_REQ match no requester and are silently dropped.
    always_comb begin
        rspHit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rspHit[i] = c0_rx_rdValid && (rspId == t_req_id'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr       <= '0;
            c0_tx_valid <= 1'b0;
            rsp_valid   <= '0;
        end else begin
            c0_tx_valid <= |grant;
            rsp_valid   <= rspHit;
            if (|grant) begin
                rrPtr <= (gntIdx == IDX_W'(N_REQ - 1)) ? '0 : gntIdx + IDX_W'(1);
            end
        end
        // Payload registers are qualified by the valids and need no reset.
        c0_tx_addr  <= gntAddr;
        c0_tx_mdata <= t_c0_mdata'{reqId: t_req_id'(gntIdx), user: gntMdata};
        rsp_mdata   <= c0_rx_mdata[12:0];
    end

    // A grant and a response to the same requester cancel out; a response
    // with nothing outstanding (e.g. issued before a reset) floors at zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (reset) begin
                outstanding[i] <= '0;
            end else if (grant[i] && !rspHit[i]) begin
                outstanding[i] <= outstanding[i] + t_outstanding_cnt'(1);
            end else if (rspHit[i] && !grant[i] && (outstanding[i] != '0)) begin
                outstanding[i] <= outstanding[i] - t_outstanding_cnt'(1);
            end
        end
    end

`ifdef CCI_RD_REQ_ARB_STATS_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (reset) begin
                stat_grants[i*32 +: 32] <= '0;
            end else if (grant[i]) begin
                stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cci_rd_req_arb.sv
// tb/tb_cci_rd_req_arb.sv - self-checking bench for cci_rd_req_arb (N_REQ=4, MAX_OUTSTANDING=2)
module tb_cci_rd_req_arb;

    localparam int N    = 4;
    localparam int MAXO = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*42-1:0]   req_addr = '0;
    logic [N*13-1:0]   req_mdata = '0;
    logic [N-1:0]      req_grant;
    logic              c0TxAlmFull = 1'b0;
    logic              c0_tx_valid;
    logic [41:0]       c0_tx_addr;
    logic [15:0]       c0_tx_mdata;
    logic              c0_rx_rdValid = 1'b0;
    logic [15:0]       c0_rx_mdata = '0;
    logic [N-1:0]      rsp_valid;
    logic [12:0]       rsp_mdata;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    cci_rd_req_arb #(
        .N_REQ           (N),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_mdata     (req_mdata),
        .req_grant     (req_grant),
        .c0TxAlmFull   (c0TxAlmFull),
        .c0_tx_valid   (c0_tx_valid),
        .c0_tx_addr    (c0_tx_addr),
        .c0_tx_mdata   (c0_tx_mdata),
        .c0_rx_rdValid (c0_rx_rdValid),
        .c0_rx_mdata   (c0_rx_mdata),
        .rsp_valid     (rsp_valid),
        .rsp_mdata     (rsp_mdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pointer, per-requester in-flight counts, and the
    // registered outputs expected in the current cycle.
    int           mPtr = 0;
    int           mOut [N];
    logic         mTxValid = 1'b0;
    logic [41:0]  mTxAddr = '0;
    logic [15:0]  mTxMdata = '0;
    logic [N-1:0] mRspValid = '0;
    logic [12:0]  mRspMdata = '0;

    initial begin
        for (int i = 0; i < N; i++) mOut[i] = 0;
    end

    always begin
        logic [N-1:0] eg;
        int gi;
        int rid;
        @(negedge clk);
        eg = '0;
        gi = -1;
        if (!reset && !c0TxAlmFull) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mPtr + k) % N;
                if (gi < 0 && req_valid[c] && mOut[c] < MAXO) gi = c;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;

        chk("model req_grant", 64'(req_grant), 64'(eg));
        chk("model c0_tx_valid", 64'(c0_tx_valid), 64'(mTxValid));
        if (mTxValid) begin
            chk("model c0_tx_addr", 64'(c0_tx_addr), 64'(mTxAddr));
            chk("model c0_tx_mdata", 64'(c0_tx_mdata), 64'(mTxMdata));
        end
        chk("model rsp_valid", 64'(rsp_valid), 64'(mRspValid));
        if (|mRspValid) chk("model rsp_mdata", 64'(rsp_mdata), 64'(mRspMdata));

        if (reset) begin
            mPtr      = 0;
            mTxValid  = 1'b0;
            mRspValid = '0;
            for (int i = 0; i < N; i++) mOut[i] = 0;
        end else begin
            mTxValid = (gi >= 0);
            if (gi >= 0) begin
                mTxAddr  = req_addr[gi*42 +: 42];
                mTxMdata = {3'(gi), req_mdata[gi*13 +: 13]};
                mPtr     = (gi + 1) % N;
            end
            rid       = int'(c0_rx_mdata[15:13]);
            mRspValid = '0;
            if (c0_rx_rdValid && rid < N) mRspValid[rid] = 1'b1;
            mRspMdata = c0_rx_mdata[12:0];
            for (int i = 0; i < N; i++) begin
                logic inc, dec;
                inc = (i == gi);
                dec = c0_rx_rdValid && (rid == i);
                if (inc && !dec) mOut[i] = mOut[i] + 1;
                else if (dec && !inc && mOut[i] > 0) mOut[i] = mOut[i] - 1;
            end
        end
    end

    // Apply one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic step(input logic [N-1:0] v, input logic af, input logic rv,
                        input logic [15:0] rm, input logic rst);
        @(posedge clk);
        #1;
        cyc++;
        reset         = rst;
        req_valid     = v;
        c0TxAlmFull   = af;
        c0_rx_rdValid = rv;
        c0_rx_mdata   = rm;
        for (int i = 0; i < N; i++) begin
            req_addr[i*42 +: 42]  = 42'(cyc * 256 + i * 16 + 5);
            req_mdata[i*13 +: 13] = 13'((cyc * 4 + i) % 8192);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] expA [5];
        int         idA  [5];
        logic [3:0] expC [4];
        expA = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        idA  = '{0, 1, 2, 3, 0};
        expC = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};

        // Reset: grants gated even with all requests pending.
        step(4'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        step(4'hF, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("reset req_grant", 64'(req_grant), 64'h0);
        chk("reset c0_tx_valid", 64'(c0_tx_valid), 64'h0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'h0);

        // All requesters valid: 0,1,2,3,0 with the id in the next cycle's mdata.
        for (int k = 0; k < 5; k++) begin
            step(4'hF, 1'b0, 1'b0, 16'h0, 1'b0);
            chk("rr grant", 64'(req_grant), 64'(expA[k]));
            if (k > 0) begin
                chk("rr tx_valid", 64'(c0_tx_valid), 64'h1);
                chk("rr tx id", 64'(c0_tx_mdata[15:13]), 64'(idA[k-1]));
            end
        end
        step(4'h0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step(4'h0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step(4'h0, 1'b0, 1'b1, 16'h2000, 1'b0);
        step(4'h0, 1'b0, 1'b1, 16'h4000, 1'b0);
        step(4'h0, 1'b0, 1'b1, 16'h6000, 1'b0);

        // Almost-full blocks grants but a registered request still issues.
        step(4'hF, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("af pre grant", 64'(req_grant), 64'h2);
        for (int k = 0; k < 5; k++) begin
            step(4'hF, 1'b1, 1'b0, 16'h0, 1'b0);
            chk("af blocked grant", 64'(req_grant), 64'h0);
            if (k == 0) chk("af issue in flight", 64'(c0_tx_valid), 64'h1);
        end
        step(4'hF, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("af resume grant", 64'(req_grant), 64'h4);
        step(4'h0, 1'b0, 1'b1, 16'h2001, 1'b0);
        step(4'h0, 1'b0, 1'b1, 16'h4002, 1'b0);
        step(4'h0, 1'b0, 1'b0, 16'h0, 1'b0);

        // Outstanding limit on requester 1, released by one response.
        for (int k = 0; k < 4; k++) begin
            step(4'b0010, 1'b0, 1'b0, 16'h0, 1'b0);
            chk("limit grant", 64'(req_grant), 64'(expC[k]));
        end
        step(4'b0010, 1'b0, 1'b1, 16'h2005, 1'b0);
        chk("limit still blocked", 64'(req_grant), 64'h0);
        step(4'b0010, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("limit rsp_valid", 64'(rsp_valid), 64'h2);
        chk("limit rsp_mdata", 64'(rsp_mdata), 64'h0005);
        chk("limit third grant", 64'(req_grant), 64'h2);
        step(4'h0, 1'b0, 1'b1, 16'h2000, 1'b0);
        step(4'h0, 1'b0, 1'b1, 16'h2000, 1'b0);

        // Grant and response to requester 2 in the same cycle.
        step(4'b0100, 1'b0, 1'b0, 16'h0, 1'b0);
        step(4'b0100, 1'b0, 1'b1, 16'h4000, 1'b0);
        chk("same-cycle grant", 64'(req_grant), 64'h4);
        step(4'b0100, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("same-cycle follow grant", 64'(req_grant), 64'h4);
        step(4'b0100, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("same-cycle now full", 64'(req_grant), 64'h0);
        step(4'h0, 1'b0, 1'b1, 16'h4000, 1'b0);
        step(4'h0, 1'b0, 1'b1, 16'h4000, 1'b0);

        // Response with id 5 is dropped.
        step(4'h0, 1'b0, 1'b1, 16'hA123, 1'b0);
        step(4'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("bad id rsp_valid", 64'(rsp_valid), 64'h0);
        step(4'hF, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("bad id then grant", 64'(req_grant), 64'h8);
        step(4'h0, 1'b0, 1'b1, 16'h6000, 1'b0);

        // Mid-run reset clears counters and the pending issue; late response floors at 0.
        step(4'b0001, 1'b0, 1'b0, 16'h0, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("pre-reset grant", 64'(req_grant), 64'h1);
        step(4'b0001, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("in-reset grant", 64'(req_grant), 64'h0);
        step(4'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("post-reset tx_valid", 64'(c0_tx_valid), 64'h0);
        step(4'h0, 1'b0, 1'b1, 16'h0007, 1'b0);
        step(4'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("late rsp_valid", 64'(rsp_valid), 64'h1);
        chk("late rsp_mdata", 64'(rsp_mdata), 64'h7);
        for (int k = 0; k < 3; k++) begin
            step(4'b0001, 1'b0, 1'b0, 16'h0, 1'b0);
            chk("post-reset grant", 64'(req_grant), (k < 2) ? 64'h1 : 64'h0);
        end
        step(4'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        step(4'h0, 1'b0, 1'b0, 16'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
